// File: rtl/display_scanner.sv
// display_scanner
// Time-multiplexed scan controller for a 4-digit common-anode seven-segment
// display. Holds a double-buffered 16-bit hex value and steps through the
// digits at SCAN_DIV cycles per slot. Each slot presents one nibble to the
// downstream decoder, drives the matching active-low anode after DEAD
// blanking cycles, and optionally suppresses leading zeros.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   synchronous active-low reset
//   load     in   strobe, captures data_in/dp_in into the shadow buffer
//   data_in  in   16 bits, digit k is data_in[4k+3:4k]
//   dp_in    in   4 bits, active-high decimal point per digit
//   blank_lz in   level, enables leading-zero suppression
//   value    out  nibble of the current digit
//   dp_n     out  active-low decimal point of the current digit
//   an       out  active-low anode enables, at most one low
//   frame    out  one-cycle pulse in the first cycle of each new frame
//   pending  out  shadow buffer holds data not yet swapped in
//
// All outputs are registers loaded from the next-state values, so they are a
// pure decode of the scan state with no combinational path from any input.

module display_scanner #(
   parameter int unsigned SCAN_DIV = 50000,
   parameter int unsigned DEAD     = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [15:0] data_in,
   input  logic [3:0]  dp_in,
   input  logic        blank_lz,
   output logic [3:0]  value,
   output logic        dp_n,
   output logic [3:0]  an,
   output logic        frame,
   output logic        pending
);

   localparam int unsigned CW = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] DEAD_C  = CW'(DEAD);

   // Digit k (k>0) is blanked when suppression is on and it and every more
   // significant digit carry neither a nonzero nibble nor a decimal point.
   function automatic logic lz_suppress(input logic [1:0]  k,
                                        input logic [15:0] d,
                                        input logic [3:0]  dp,
                                        input logic        en);
      logic hit;
      hit = en & (k != 2'd0);
      for (int j = 0; j < 4; j++) begin
         hit = hit & ~((j >= int'(k)) & ((d[4*j +: 4] != 4'd0) | dp[j]));
      end
      return hit;
   endfunction

   logic [CW-1:0] cnt_r,      cnt_nxt_s;
   logic [1:0]    idx_r,      idx_nxt_s;
   logic [15:0]   sh_data_r,  sh_data_nxt_s;
   logic [3:0]    sh_dp_r,    sh_dp_nxt_s;
   logic [15:0]   act_data_r, act_data_nxt_s;
   logic [3:0]    act_dp_r,   act_dp_nxt_s;
   logic          pending_r,  pending_nxt_s;
   logic          frame_r,    frame_nxt_s;
   logic [3:0]    value_r,    value_nxt_s;
   logic          dp_n_r,     dp_n_nxt_s;
   logic [3:0]    an_r,       an_nxt_s;
   logic          tick_s, boundary_s, blank_s, dp_bit_s;

   // Next-state for counters and buffers, plus decode of the next outputs.
   always_comb begin
      tick_s         = (cnt_r == CNT_MAX);
      boundary_s     = tick_s & (idx_r == 2'd3);
      cnt_nxt_s      = tick_s ? '0 : cnt_r + CW'(1);
      idx_nxt_s      = tick_s ? idx_r + 2'd1 : idx_r;
      frame_nxt_s    = boundary_s;
      sh_data_nxt_s  = sh_data_r;
      sh_dp_nxt_s    = sh_dp_r;
      act_data_nxt_s = act_data_r;
      act_dp_nxt_s   = act_dp_r;
      pending_nxt_s  = pending_r;
      value_nxt_s    = 4'd0;
      an_nxt_s       = 4'b1111;
      dp_bit_s       = 1'b0;

      if (load) begin
         sh_data_nxt_s = data_in;
         sh_dp_nxt_s   = dp_in;
         pending_nxt_s = 1'b1;
      end else begin
         pending_nxt_s = pending_r;
      end

      // A load on the boundary bypasses the shadow so it is shown at once.
      if (boundary_s) begin
         if (load) begin
            act_data_nxt_s = data_in;
            act_dp_nxt_s   = dp_in;
         end else if (pending_r) begin
            act_data_nxt_s = sh_data_r;
            act_dp_nxt_s   = sh_dp_r;
         end else begin
            act_data_nxt_s = act_data_r;
            act_dp_nxt_s   = act_dp_r;
         end
         pending_nxt_s = 1'b0;
      end else begin
         act_data_nxt_s = act_data_r;
         act_dp_nxt_s   = act_dp_r;
      end

      case (idx_nxt_s)
         2'd0:    begin value_nxt_s = act_data_nxt_s[3:0];   an_nxt_s = 4'b1110; dp_bit_s = act_dp_nxt_s[0]; end
         2'd1:    begin value_nxt_s = act_data_nxt_s[7:4];   an_nxt_s = 4'b1101; dp_bit_s = act_dp_nxt_s[1]; end
         2'd2:    begin value_nxt_s = act_data_nxt_s[11:8];  an_nxt_s = 4'b1011; dp_bit_s = act_dp_nxt_s[2]; end
         2'd3:    begin value_nxt_s = act_data_nxt_s[15:12]; an_nxt_s = 4'b0111; dp_bit_s = act_dp_nxt_s[3]; end
         default: begin value_nxt_s = 4'd0;                  an_nxt_s = 4'b1111; dp_bit_s = 1'b0;            end
      endcase

      blank_s = (cnt_nxt_s < DEAD_C) |
                lz_suppress(idx_nxt_s, act_data_nxt_s, act_dp_nxt_s, blank_lz);
      if (blank_s) begin
         an_nxt_s   = 4'b1111;
         dp_n_nxt_s = 1'b1;
      end else begin
         dp_n_nxt_s = ~dp_bit_s;
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_r      <= '0;
         idx_r      <= 2'd0;
         sh_data_r  <= 16'd0;
         sh_dp_r    <= 4'd0;
         act_data_r <= 16'd0;
         act_dp_r   <= 4'd0;
         pending_r  <= 1'b0;
         frame_r    <= 1'b0;
         value_r    <= 4'd0;
         dp_n_r     <= 1'b1;
         an_r       <= 4'b1111;
      end else begin
         cnt_r      <= cnt_nxt_s;
         idx_r      <= idx_nxt_s;
         sh_data_r  <= sh_data_nxt_s;
         sh_dp_r    <= sh_dp_nxt_s;
         act_data_r <= act_data_nxt_s;
         act_dp_r   <= act_dp_nxt_s;
         pending_r  <= pending_nxt_s;
         frame_r    <= frame_nxt_s;
         value_r    <= value_nxt_s;
         dp_n_r     <= dp_n_nxt_s;
         an_r       <= an_nxt_s;
      end
   end

   assign value   = value_r;
   assign dp_n    = dp_n_r;
   assign an      = an_r;
   assign frame   = frame_r;
   assign pending = pending_r;

endmodule
